// File: rtl/cla_pkg.sv
// Shared definitions for the multi-precision carry-lookahead adder controller:
// FSM state encodings and the word-index width helper.
// Imported by the controller; the slice adder itself is parameter-only.
package cla_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits needed to index n words; never less than one so NW==1 still has a
   // legal index register.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/cla_slice_add.sv
// Purpose: combinational W-bit carry-lookahead adder slice.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the caller decides when the result is used.
module cla_slice_add #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W-1:0] gen;
   logic [W-1:0] prop;
   logic [W:0]   carry;

   assign gen  = a & b;
   assign prop = a ^ b;

   // Carry into bit top+1 as a flat sum of products: each generate term is
   // gated by the propagates above it, and cin by all propagates 0..top.
   function automatic logic lookahead(input logic [W-1:0] gv,
                                      input logic [W-1:0] pv,
                                      input logic         ci,
                                      input int           top);
      logic acc;
      logic pp;
      acc = 1'b0;
      pp  = 1'b1;
      for (int j = W - 1; j >= 0; j--) begin
         if (j <= top) begin
            acc = acc | (gv[j] & pp);
            pp  = pp & pv[j];
         end
      end
      return acc | (ci & pp);
   endfunction

   // Every carry is computed directly from g/p/cin rather than from its
   // neighbour, so no carry waits on another carry.
   always_comb begin
      carry    = '0;
      carry[0] = cin;
      for (int i = 0; i < W; i++) begin
         carry[i+1] = lookahead(gen, prop, cin, i);
      end
   end

   assign sum  = prop ^ carry[W-1:0];
   assign cout = carry[W];

endmodule

// File: rtl/cla_mp_add_ctrl.sv
// Purpose: NW-word unsigned adder that reuses one W-bit CLA slice, LS word first.
// Latency: NW+2 cycles per operation (accept, NW slice cycles, result hold).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module cla_mp_add_ctrl
   import cla_pkg::*;
#(
   parameter int W  = 8,
   parameter int NW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [NW*W-1:0] a_in,
   input  logic [NW*W-1:0] b_in,
   input  logic            c_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [NW*W:0]   sum_out,
   output logic            busy
);

   localparam int             IW       = clog2(NW);
   localparam logic [IW-1:0]  LAST_IDX = IW'(NW - 1);

   typedef struct packed {
      logic [NW*W-1:0] a;
      logic [NW*W-1:0] b;
   } operands_t;

   state_t        state_q;
   state_t        state_d;
   operands_t     ops_q;
   logic [IW-1:0] idx_q;
   logic          carry_q;
   logic [NW*W:0] sum_q;

   logic          accept;
   logic          last_word;
   logic [W-1:0]  a_word;
   logic [W-1:0]  b_word;
   logic [W-1:0]  slice_sum;
   logic          slice_cout;

   assign last_word = (idx_q == LAST_IDX);

   // State register; reset wins over any handshake in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode and the input-side accept strobe.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (last_word) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Select the current word of each latched operand for the slice.
   always_comb begin
      a_word = '0;
      b_word = '0;
      for (int k = 0; k < NW; k++) begin
         if (idx_q == IW'(k)) begin
            a_word = ops_q.a[k*W +: W];
            b_word = ops_q.b[k*W +: W];
         end
      end
   end

   cla_slice_add #(
      .W (W)
   ) u_slice (
      .a    (a_word),
      .b    (b_word),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // Operand latch, word index, inter-word carry and result accumulation.
   // Operands load only on accept, so input activity outside IDLE is inert.
   always_ff @(posedge clk) begin
      if (rst) begin
         ops_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
      end else if (accept) begin
         ops_q.a <= a_in;
         ops_q.b <= b_in;
         idx_q   <= '0;
         carry_q <= c_in;
      end else if (state_q == RUN) begin
         carry_q <= slice_cout;
         // Wrap explicitly so a non-power-of-two NW never leaves the range.
         idx_q   <= last_word ? '0 : idx_q + IW'(1);
         for (int k = 0; k < NW; k++) begin
            if (idx_q == IW'(k)) begin
               sum_q[k*W +: W] <= slice_sum;
            end
         end
         if (last_word) begin
            sum_q[NW*W] <= slice_cout;
         end
      end
   end

   // Outputs come straight from state or registers.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum_out   = sum_q;

endmodule

// File: tb/tb_cla_mp_add_ctrl.sv
// Purpose: scoreboard bench for cla_mp_add_ctrl at W=8, NW=4.
// Latency: expects out_valid NW+1 edges after the offer cycle, NW+2 per op.
// Backpressure: exercises out_ready low holds and in_valid while busy.
module tb_cla_mp_add_ctrl;

   localparam int W  = 8;
   localparam int NW = 4;
   localparam int DW = NW * W;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] a_in;
   logic [DW-1:0] b_in;
   logic          c_in;
   logic          out_valid;
   logic          out_ready;
   logic [DW:0]   sum_out;
   logic          busy;

   int            vectors     = 0;
   int            miscompares = 0;
   longint        cycle       = 0;
   logic [DW:0]   exp_q[$];

   cla_mp_add_ctrl #(.W(W), .NW(NW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum_out   (sum_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   function automatic logic [DW:0] ref_sum(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic c);
      return {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, c};
   endfunction

   function automatic logic [DW:0] pop_exp();
      if (exp_q.size() == 0) return 'x;
      return exp_q.pop_front();
   endfunction

   // Offer one operand pair (called just after an edge) and hold it until the
   // handshake edge; the reference result is queued at that edge.
   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic c);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL send_ready: in_ready=%b required 1", in_ready);
      end
      a_in = a; b_in = b; c_in = c; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_q.push_back(ref_sum(a, b, c));
   endtask

   // Edges until out_valid, counting the accepting edge as the first.
   task automatic wait_valid(output int edges);
      edges = 1;
      while (!out_valid && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; a_in = '1; b_in = '1; c_in = 1'b1; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0;
      vectors += 4;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      if (sum_out !== '0) begin miscompares++; $display("FAIL reset_sum: got %h want 0", sum_out); end
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_no_accept: busy=%b want 0", busy); end
   endtask

   task automatic test_carry_chain();
      int e;
      logic [DW:0] exp;
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      vectors += 2;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL chain_busy: got %b want 1", busy); end
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL chain_in_ready: got %b want 0", in_ready); end
      wait_valid(e);
      exp = pop_exp();
      vectors += 2;
      if (e !== NW + 1) begin miscompares++; $display("FAIL chain_latency: got %0d want %0d", e, NW + 1); end
      if (sum_out !== exp) begin miscompares++; $display("FAIL chain_sum: got %h want %h", sum_out, exp); end
      @(posedge clk); #1;
      vectors += 2;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL chain_consumed: out_valid=%b want 0", out_valid); end
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL chain_idle: in_ready=%b want 1", in_ready); end
   endtask

   task automatic test_all_ones();
      int e;
      logic [DW:0] exp;
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      wait_valid(e);
      exp = pop_exp();
      vectors++;
      if (sum_out !== exp) begin miscompares++; $display("FAIL all_ones_sum: got %h want %h", sum_out, exp); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int e;
      logic [DW:0] exp;
      out_ready = 1'b0;
      send(32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
      wait_valid(e);
      exp = pop_exp();
      vectors++;
      if (sum_out !== exp) begin miscompares++; $display("FAIL hold_sum: got %h want %h", sum_out, exp); end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         vectors += 2;
         if (out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); end
         if (sum_out !== exp) begin miscompares++; $display("FAIL hold_stable[%0d]: got %h want %h", i, sum_out, exp); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL hold_release: out_valid=%b want 0", out_valid); end
   endtask

   task automatic test_ignore_inflight();
      int e;
      logic [DW:0] exp;
      send(32'h1111_1111, 32'h2222_2222, 1'b1);
      a_in = 32'hAAAA_AAAA; b_in = 32'hAAAA_AAAA; c_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL inflight_in_ready: got %b want 0", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(e);
      exp = pop_exp();
      vectors++;
      if (sum_out !== exp) begin miscompares++; $display("FAIL inflight_sum: got %h want %h", sum_out, exp); end
      repeat (8) @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL inflight_no_extra: busy=%b out_valid=%b want 0 0", busy, out_valid);
      end
   endtask

   task automatic test_reset_abort();
      int e;
      logic [DW:0] exp;
      logic seen = 1'b0;
      send(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      void'(pop_exp());
      vectors += 4;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL abort_out_valid: got %b want 0", out_valid); end
      if (sum_out !== '0) begin miscompares++; $display("FAIL abort_sum: got %h want 0", sum_out); end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin miscompares++; $display("FAIL abort_no_result: out_valid rose=%b want 0", seen); end
      send(32'h0000_0001, 32'h0000_0001, 1'b0);
      wait_valid(e);
      exp = pop_exp();
      vectors++;
      if (sum_out !== exp) begin miscompares++; $display("FAIL abort_next_sum: got %h want %h", sum_out, exp); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int     got  = 0;
      longint last = -1;
      longint limit;
      logic [DW:0] exp;
      limit = cycle + 1000 * (NW + 2) + 200;
      out_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               send($urandom, $urandom, 1'($urandom_range(0, 1)));
            end
         end
         begin
            while (got < 1000 && cycle < limit) begin
               @(negedge clk);
               if (out_valid) begin
                  exp = pop_exp();
                  vectors++;
                  if (sum_out !== exp) begin
                     miscompares++;
                     $display("FAIL b2b_sum[%0d]: got %h want %h", got, sum_out, exp);
                  end
                  if (last >= 0) begin
                     vectors++;
                     if (cycle - last != NW + 2) begin
                        miscompares++;
                        $display("FAIL b2b_spacing[%0d]: got %0d want %0d", got, cycle - last, NW + 2);
                     end
                  end
                  last = cycle;
                  got++;
               end
            end
         end
      join
      vectors += 2;
      if (got != 1000) begin miscompares++; $display("FAIL b2b_count: got %0d want 1000", got); end
      if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_carry_chain();
      test_all_ones();
      test_backpressure();
      test_ignore_inflight();
      test_reset_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
